cp0_exception_unit: RTL and testbench
=====================================

# cp0_exception_unit

Exception and interrupt dispatch unit for the CP0 coprocessor. It reads the pending-interrupt bits from CAUSE (CP0 Reg 13) and the enables from STATUS (CP0 Reg 12), arbitrates against synchronous exception requests from the pipeline, and drains the pipeline. It then drives the `activeexception`/`exccode` pair that the CAUSE register records, writes EPC, sets or clears EXL, and redirects fetch to the handler vector or, on ERET, back to EPC.

## Interface

Parameters:
- `EXC_VECTOR`, 32'h8000_0180, handler entry address.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cause`  in  32  CAUSE register value; IP in [15:8].
- `status`  in  32  STATUS register value; IE = bit 0, EXL = bit 1, IM = [15:8].
- `epc`  in  32  current EPC value; used as the ERET target.
- `exc_req`  in  1  synchronous exception request from the pipeline.
- `exc_code_in`  in  5  ExcCode of the request.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_bd`  in  1  faulting instruction is in a branch delay slot.
- `eret_req`  in  1  ERET reached commit.
- `commit_pc`  in  32  PC of the next instruction to commit; becomes EPC for interrupts.
- `pipe_drained`  in  1  pipeline is empty after the flush.
- `redirect_ack`  in  1  fetch accepted the redirect.
- `activeexception`  out  1  one-cycle pulse to the CAUSE register.
- `exccode`  out  5  code presented with `activeexception`.
- `epc_we`  out  1  EPC write enable (one-cycle pulse).
- `epc_wdata`  out  32  EPC write data.
- `bd`  out  1  delay-slot flag presented with `epc_we`.
- `exl_set`  out  1  set STATUS.EXL (one-cycle pulse).
- `exl_clr`  out  1  clear STATUS.EXL (one-cycle pulse).
- `flush`  out  1  squash all in-flight instructions.
- `redirect_valid`  out  1  new fetch PC is valid.
- `redirect_pc`  out  32  new fetch PC.
- `busy`  out  1  state is not IDLE.

## Operation

- Interrupt detection: `int_take = status[0] & ~status[1] & |(cause[15:8] & status[15:8])`.
- FSM states: IDLE, FLUSH, COMMIT, REDIRECT, ERET.
- Arbitration in IDLE, highest priority first: `exc_req` > `int_take` > `eret_req`.
  - Exception: capture code = `exc_code_in`, PC = `exc_pc`, BD = `exc_bd`; go to FLUSH.
  - Interrupt: capture code = 5'd0, PC = `commit_pc`, BD = 0; go to FLUSH.
  - ERET with `status[1]=1`: go to ERET.
  - ERET with `status[1]=0`: ignored; stay in IDLE.
- FLUSH: `flush=1`. Hold until `pipe_drained=1`, then go to COMMIT.
- COMMIT (exactly one cycle):
  - `activeexception=1`, `exccode=`captured code.
  - `epc_we=1`, `epc_wdata = BD ? PC-4 : PC` (32-bit modulo arithmetic), `bd=`captured BD.
  - `exl_set=1`.
  - Next state: REDIRECT.
- REDIRECT: `redirect_valid=1`, `redirect_pc=EXC_VECTOR`. Hold until `redirect_ack=1`, then go to IDLE.
- ERET state: `flush=1`, `exl_clr=1` (one cycle), `redirect_valid=1`, `redirect_pc=epc` (sampled on entry). Hold until `redirect_ack=1`, then go to IDLE. `exl_clr` pulses only in the first cycle.
- While `busy=1`, `exc_req`, `eret_req` and interrupts are ignored; the pipeline is flushed, so requests are not queued.
- `exccode` and `epc_wdata` hold their last values outside pulses; consumers qualify them by their strobes.

## Timing

- All outputs are registered, Moore style.
- Reset (`reset=0` at an edge): state returns to IDLE. Every output goes to 0, including `exccode`, `epc_wdata`, `redirect_pc`.
- Reset asserted mid-sequence aborts it; no pending pulse is emitted afterwards.
- Request sampled in IDLE at edge N:
  - `busy=1` and `flush=1` from cycle N+1.
  - `pipe_drained` high in cycle N+1 → COMMIT pulses in cycle N+2; `redirect_valid` from cycle N+3.
  - Minimum request-to-redirect latency: 3 cycles.
- `redirect_ack` in the first REDIRECT cycle → IDLE the next cycle. A new request can be sampled in that IDLE cycle.
- The CAUSE register latches `exccode` on the edge that ends the COMMIT cycle.
- STATUS.EXL becomes 1 one cycle after COMMIT, which blocks nested interrupts.
- `exc_req` and `int_take` in the same IDLE cycle: the exception wins. The interrupt stays pending in CAUSE and is blocked afterwards by EXL.
- `eret_req` and `exc_req` in the same cycle: the exception wins and the ERET is dropped.

## Test plan

- Interrupt: `status=32'h0000_0401`, `cause[10]=1`, `commit_pc=32'h0040_0010`, drained immediately → `activeexception` pulse with `exccode=0`, `epc_wdata=32'h0040_0010`, `exl_set` pulse, `redirect_pc=32'h8000_0180`; first `redirect_valid` 3 cycles after the sample edge.
- Sync exception in delay slot: `exc_req`, code 5'd12, `exc_pc=32'h0040_0104`, `exc_bd=1`; `pipe_drained` held low 4 cycles → `flush` high 5 cycles, then `exccode=12`, `epc_wdata=32'h0040_0100`, `bd=1`.
- Simultaneous `exc_req` (code 4) and enabled interrupt → `exccode=4`. No second dispatch follows, because EXL is set.
- ERET with `status[1]=1`, `epc=32'h0040_0200` → `exl_clr` one-cycle pulse, `redirect_pc=32'h0040_0200`, no `activeexception`. Same stimulus with `status[1]=0` → `busy` stays 0.
- `redirect_ack` held low 6 cycles → `redirect_valid` and `redirect_pc` stable throughout; `exc_req` pulses during `busy` are ignored.
- `reset=0` during FLUSH → next cycle all outputs 0, state IDLE. No `activeexception` appears after release.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// CP0 exception/interrupt dispatch: arbitrates requests, drains the pipeline,
// pulses the CAUSE/EPC/EXL updates and redirects fetch to the handler or EPC.
module cp0_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cause,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    input  logic        exc_req,
    input  logic [4:0]  exc_code_in,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret_req,
    input  logic [31:0] commit_pc,
    input  logic        pipe_drained,
    input  logic        redirect_ack,
    output logic        activeexception,
    output logic [4:0]  exccode,
    output logic        epc_we,
    output logic [31:0] epc_wdata,
    output logic        bd,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, FLUSH, COMMIT, REDIRECT, ERET} state_t;

    state_t      state, next_state;
    logic        int_take;
    logic [4:0]  cap_code;
    logic [31:0] cap_pc;
    logic        cap_bd;

    logic        activeexception_n, epc_we_n, bd_n, exl_set_n, exl_clr_n;
    logic        flush_n, redirect_valid_n, busy_n;
    logic [4:0]  exccode_n;
    logic [31:0] epc_wdata_n, redirect_pc_n;

    logic unused_bits;
    assign unused_bits = ^{cause[31:16], cause[7:0], status[31:16], status[7:2]};

    // Outputs are computed for the state being entered and then registered,
    // so every output is a clean Moore-style flop.
    always_comb begin
        int_take   = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
        next_state = state;
        case (state)
            IDLE: begin
                if (exc_req || int_take)
                    next_state = FLUSH;
                else if (eret_req && status[1])
                    next_state = ERET;
            end
            FLUSH:    if (pipe_drained) next_state = COMMIT;
            COMMIT:   next_state = REDIRECT;
            REDIRECT: if (redirect_ack) next_state = IDLE;
            ERET:     if (redirect_ack) next_state = IDLE;
            default:  next_state = IDLE;
        endcase

        activeexception_n = (next_state == COMMIT);
        epc_we_n          = (next_state == COMMIT);
        exl_set_n         = (next_state == COMMIT);
        exl_clr_n         = (state == IDLE) && (next_state == ERET);
        flush_n           = (next_state == FLUSH) || (next_state == ERET);
        redirect_valid_n  = (next_state == REDIRECT) || (next_state == ERET);
        busy_n            = (next_state != IDLE);

        // Data outputs hold their last value; consumers qualify by strobe.
        exccode_n     = exccode;
        epc_wdata_n   = epc_wdata;
        bd_n          = bd;
        redirect_pc_n = redirect_pc;
        if (next_state == COMMIT) begin
            exccode_n   = cap_code;
            epc_wdata_n = cap_bd ? (cap_pc - 32'd4) : cap_pc;
            bd_n        = cap_bd;
        end
        if (state != REDIRECT && next_state == REDIRECT)
            redirect_pc_n = EXC_VECTOR;
        else if (state == IDLE && next_state == ERET)
            redirect_pc_n = epc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            cap_code        <= '0;
            cap_pc          <= '0;
            cap_bd          <= 1'b0;
            activeexception <= 1'b0;
            exccode         <= '0;
            epc_we          <= 1'b0;
            epc_wdata       <= '0;
            bd              <= 1'b0;
            exl_set         <= 1'b0;
            exl_clr         <= 1'b0;
            flush           <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            busy            <= 1'b0;
        end else begin
            state           <= next_state;
            activeexception <= activeexception_n;
            exccode         <= exccode_n;
            epc_we          <= epc_we_n;
            epc_wdata       <= epc_wdata_n;
            bd              <= bd_n;
            exl_set         <= exl_set_n;
            exl_clr         <= exl_clr_n;
            flush           <= flush_n;
            redirect_valid  <= redirect_valid_n;
            redirect_pc     <= redirect_pc_n;
            busy            <= busy_n;
            // Interrupts record EPC = next commit PC with no delay-slot adjust.
            if (state == IDLE) begin
                if (exc_req) begin
                    cap_code <= exc_code_in;
                    cap_pc   <= exc_pc;
                    cap_bd   <= exc_bd;
                end else if (int_take) begin
                    cap_code <= 5'd0;
                    cap_pc   <= commit_pc;
                    cap_bd   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Scoreboard bench for cp0_exception_unit: directed scenarios push expected
// commit/redirect records, a negedge monitor pops and compares them.
module tb_cp0_exception_unit;

    localparam logic [31:0] VEC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cause, status, epc, exc_pc, commit_pc;
    logic        exc_req, exc_bd, eret_req, pipe_drained, redirect_ack;
    logic [4:0]  exc_code_in;

    logic        activeexception, epc_we, bd, exl_set, exl_clr;
    logic        flush, redirect_valid, busy;
    logic [4:0]  exccode;
    logic [31:0] epc_wdata, redirect_pc;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] wdata;
        logic        bd;
    } commit_t;

    typedef struct {
        logic [31:0] pc;
        logic        is_eret;
    } redir_t;

    commit_t exp_commit[$];
    redir_t  exp_redir[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_exception_unit #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .cause(cause), .status(status), .epc(epc),
        .exc_req(exc_req), .exc_code_in(exc_code_in), .exc_pc(exc_pc),
        .exc_bd(exc_bd), .eret_req(eret_req), .commit_pc(commit_pc),
        .pipe_drained(pipe_drained), .redirect_ack(redirect_ack),
        .activeexception(activeexception), .exccode(exccode), .epc_we(epc_we),
        .epc_wdata(epc_wdata), .bd(bd), .exl_set(exl_set), .exl_clr(exl_clr),
        .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of a request, then clears the request strobes.
    task automatic applyStimulus(input logic ex, input logic [4:0] code,
                                 input logic [31:0] pc, input logic isbd,
                                 input logic er);
        exc_req     = ex;
        exc_code_in = code;
        exc_pc      = pc;
        exc_bd      = isbd;
        eret_req    = er;
        tick();
        exc_req  = 1'b0;
        eret_req = 1'b0;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_exccode"}, {27'd0, exccode}, 32'd0);
        checkOutput({tag, "_epc_wdata"}, epc_wdata, 32'd0);
        checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        checkOutput({tag, "_strobes"},
                    {23'd0, activeexception, epc_we, bd, exl_set, exl_clr,
                     flush, redirect_valid, busy, 1'b0}, 32'd0);
    endtask

    // Monitor: pops an expectation on each commit pulse and on each redirect.
    initial begin : monitor
        logic        prev_rv;
        logic [31:0] cur_pc;
        prev_rv = 1'b0;
        cur_pc  = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (activeexception) begin
                    if (exp_commit.size() == 0) begin
                        checkOutput("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        commit_t c;
                        c = exp_commit.pop_front();
                        checkOutput("exccode", {27'd0, exccode}, {27'd0, c.code});
                        checkOutput("epc_wdata", epc_wdata, c.wdata);
                        checkOutput("bd", {31'd0, bd}, {31'd0, c.bd});
                        checkOutput("commit_strobes", {30'd0, epc_we, exl_set}, 32'd3);
                    end
                end
                if (redirect_valid && !prev_rv) begin
                    if (exp_redir.size() == 0) begin
                        checkOutput("unexpected_redirect", 32'd1, 32'd0);
                    end else begin
                        redir_t r;
                        r = exp_redir.pop_front();
                        cur_pc = r.pc;
                        checkOutput("redirect_pc", redirect_pc, r.pc);
                        checkOutput("exl_clr_first", {31'd0, exl_clr}, {31'd0, r.is_eret});
                    end
                end else if (redirect_valid && prev_rv) begin
                    checkOutput("redirect_pc_stable", redirect_pc, cur_pc);
                    checkOutput("exl_clr_later", {31'd0, exl_clr}, 32'd0);
                end
                prev_rv = redirect_valid;
            end else begin
                prev_rv = 1'b0;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0; cause = '0; status = '0; epc = '0; exc_pc = '0;
        commit_pc = '0; exc_req = 0; exc_bd = 0; eret_req = 0;
        exc_code_in = '0; pipe_drained = 1'b1; redirect_ack = 1'b1;
        repeat (3) tick();
        checkIdleZero("reset");
        reset = 1'b1;
        tick();

        $display("[TB] interrupt dispatch");
        status = 32'h0000_0401; cause = 32'h0000_0400; commit_pc = 32'h0040_0010;
        exp_commit.push_back('{5'd0, 32'h0040_0010, 1'b0});
        exp_redir.push_back('{VEC, 1'b0});
        tick();
        checkOutput("int_busy_n1", {30'd0, busy, flush}, 32'd3);
        checkOutput("int_rv_n1", {31'd0, redirect_valid}, 32'd0);
        tick();
        checkOutput("int_commit_n2", {31'd0, activeexception}, 32'd1);
        status = 32'h0000_0403;
        tick();
        checkOutput("int_rv_n3", {31'd0, redirect_valid}, 32'd1);
        tick();
        checkOutput("int_idle", {31'd0, busy}, 32'd0);
        status = '0; cause = '0;

        $display("[TB] delay-slot exception");
        pipe_drained = 1'b0;
        exp_commit.push_back('{5'd12, 32'h0040_0100, 1'b1});
        exp_redir.push_back('{VEC, 1'b0});
        applyStimulus(1'b1, 5'd12, 32'h0040_0104, 1'b1, 1'b0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (flush) n++;
            if (i == 4) pipe_drained = 1'b1;
            if (i < 4) tick();
        end
        tick();
        checkOutput("exc_flush_cycles", n, 32'd5);
        checkOutput("exc_flush_done", {30'd0, flush, activeexception}, 32'd1);
        tick();
        tick();
        checkOutput("exc_idle", {31'd0, busy}, 32'd0);

        $display("[TB] exception beats interrupt");
        status = 32'h0000_0401; cause = 32'h0000_0400;
        exp_commit.push_back('{5'd4, 32'h0040_0300, 1'b0});
        exp_redir.push_back('{VEC, 1'b0});
        applyStimulus(1'b1, 5'd4, 32'h0040_0300, 1'b0, 1'b0);
        tick();
        status = 32'h0000_0403;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("no_nested", {31'd0, busy}, 32'd0);
            tick();
        end
        status = '0; cause = '0;

        $display("[TB] eret");
        status = 32'h0000_0002; epc = 32'h0040_0200; redirect_ack = 1'b0;
        exp_redir.push_back('{32'h0040_0200, 1'b1});
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("eret_first", {28'd0, busy, flush, exl_clr, activeexception}, 32'he);
        epc = 32'h1234_5678;
        tick();
        checkOutput("eret_second", {29'd0, flush, exl_clr, redirect_valid}, 32'h5);
        checkOutput("eret_pc_hold", redirect_pc, 32'h0040_0200);
        redirect_ack = 1'b1;
        tick();
        checkOutput("eret_idle", {31'd0, busy}, 32'd0);
        status = '0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("eret_ignored", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("eret_ignored2", {31'd0, busy}, 32'd0);

        $display("[TB] slow redirect ack");
        redirect_ack = 1'b0;
        exp_commit.push_back('{5'd8, 32'h0040_0400, 1'b0});
        exp_redir.push_back('{VEC, 1'b0});
        applyStimulus(1'b1, 5'd8, 32'h0040_0400, 1'b0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            checkOutput("hold_rv", {31'd0, redirect_valid}, 32'd1);
            checkOutput("hold_pc", redirect_pc, VEC);
            exc_req = i[0]; exc_code_in = 5'd9; eret_req = ~i[0];
            tick();
        end
        exc_req = 1'b0; eret_req = 1'b0; redirect_ack = 1'b1;
        tick();
        checkOutput("hold_idle", {31'd0, busy}, 32'd0);

        $display("[TB] reset during flush");
        pipe_drained = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'h0040_0500, 1'b0, 1'b0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd1);
        reset = 1'b0;
        tick();
        checkIdleZero("rst_mid");
        reset = 1'b1; pipe_drained = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_no_pulse", {30'd0, activeexception, busy}, 32'd0);
        end

        tick();
        checkOutput("commit_queue_empty", exp_commit.size(), 32'd0);
        checkOutput("redir_queue_empty", exp_redir.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
